bram_add_seq: RTL and testbench
===============================

# bram_add_seq

Sequencer and adder that feeds the result memory `bram3`. On a start command it sweeps an address range, reads operand words from `bram1` and `bram2` in lockstep, adds each pair and writes the sum to the same address in `bram3` through that wrapper's port-A signals. One element per cycle is issued, with the pipeline depth matched to the BRAM read latency.

## Interface
- `ADDR_W`, 8, address width of all three memories
- `DATA_W`, 16, word width of operands and result
- `RD_LAT`, 1, BRAM read latency in cycles; legal values are 1 or 2

- `clk` in 1: single clock, shared with all three BRAMs
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: request a sweep; sampled only in IDLE
- `first_addr` in ADDR_W: first address, sampled with an accepted `start`
- `last_addr` in ADDR_W: last address (inclusive), sampled with an accepted `start`
- `busy` out 1: sweep in progress
- `done` out 1: one-cycle completion pulse
- `ovf` out 1: sticky carry-out flag for the current or last sweep
- `ena1`, `addra1` out 1/ADDR_W: `bram1` read port
- `douta1` in DATA_W: `bram1` read data
- `ena2`, `addra2` out 1/ADDR_W: `bram2` read port
- `douta2` in DATA_W: `bram2` read data
- `ena3`, `wea3`, `addra3`, `dina3` out 1/1/ADDR_W/DATA_W: `bram3` write port

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE.** `start`=1 latches `first_addr` and `last_addr`, clears `ovf` and moves to RUN.
- **RUN.** Each cycle:
  - `ena1`=`ena2`=1 and `addra1`=`addra2`=rd_addr.
  - rd_addr increments modulo 2^ADDR_W.
  - After the cycle that issues `last_addr`, the FSM goes to DRAIN.
- **Element count.** N = ((last−first) mod 2^ADDR_W) + 1, so N is between 1 and 256. When `last_addr`<`first_addr` the sweep wraps from 255 to 0. When `last_addr`=`first_addr`, N=1.
- **DRAIN.** Lasts RD_LAT cycles with no reads; it flushes the pipeline.
- **DONE.** Lasts one cycle with `done`=1, then the FSM returns to IDLE.
- **Pipeline.** A valid/address delay line of depth RD_LAT tracks each read.
- **Write.** When a delayed valid emerges:
  - `ena3`=`wea3`=1.
  - `addra3`=delayed address.
  - `dina3`=`douta1`+`douta2` (low DATA_W bits).
- **Overflow.** The carry bit (bit DATA_W of the DATA_W+1 sum) sets `ovf`. `ovf` holds until the next accepted `start`.
- **Ignored start.** `start` in any state other than IDLE is ignored.
- **Reset mid-sweep.**
  - The FSM goes to IDLE and the delay line is cleared.
  - No further writes occur.
  - Partial results already in `bram3` remain.
- **Reset values:**
  - `busy`, `done` and `ovf` are 0.
  - All `ena*`, `wea3`, `addra*` and `dina3` are 0.
- Outside write cycles, `ena3`/`wea3` are 0 and `addra3`/`dina3` hold 0.

## Timing
- **Start.** `start` is accepted at edge 0. The first read (`first_addr`) is issued in cycle 1.
- **Element k reads.** Element k (0-based) is read in cycle 1+k.
- **Element k writes.** Element k is written in cycle 1+k+RD_LAT. Reads and writes to different stages overlap.
- **Throughput.** One element per cycle, with no bubbles.
- **busy.** High from cycle 1 through cycle N+RD_LAT (the last write).
- **done.** High in cycle N+RD_LAT+1, when `busy`=0.
- **Back-to-back sweeps.** The earliest next `start` is accepted in the cycle after `done`.
- **Total latency.** N+RD_LAT+1 cycles from `start` to `done`.

## Configuration
- **Macro:** `BRAM_ADD_SATURATE_EN`.
- **Defined:** on carry-out, `dina3` = all ones (unsigned saturation). `ovf` behaviour is unchanged.
- **Undefined:** `dina3` wraps modulo 2^DATA_W.

## Structure
- **Package `bram_add_pkg`:**
  - `ADDR_W` and `DATA_W` default constants.
  - State enum `seq_state_t` {IDLE, RUN, DRAIN, DONE}.
  - Sum type of width DATA_W+1.
- **Sub-module `bram_add_pipe`:** the RD_LAT-deep valid+address delay line, with async active-low clear. The top level holds the FSM, address counter, adder and flags.

## Test plan
- **Basic sweep.** RD_LAT=1, first=0, last=3, `bram1`[i]=i, `bram2`[i]=0x10. `bram3`[0..3] = 0x10, 0x11, 0x12, 0x13. `done` pulses in cycle 6. `ovf`=0.
- **Wrap-around.** first=0xFE, last=0x01, RD_LAT=2. Exactly 4 writes occur, to 0xFE, 0xFF, 0x00, 0x01 in that order. `done` pulses in cycle 7.
- **Overflow.** `bram1`[5]=0xFFFF, `bram2`[5]=0x0002, single element 5. Without the macro `bram3`[5]=0x0001; with `BRAM_ADD_SATURATE_EN`, 0xFFFF. `ovf`=1 until the next `start`.
- **Full range and ignored start.** first=0, last=0xFF runs 256 writes with `busy` high for 257 cycles. A `start` pulsed mid-sweep has no effect.
- **Reset mid-sweep.** Assert `rst_n`=0 in cycle 3 of a 10-element sweep. All outputs go to 0 immediately. After release there are no further `ena3` pulses, and a new `start` runs normally.

Source files
------------

// File: rtl/bram_add_pkg.sv
// Shared constants and types for the bram_add_seq sweep/add block.
package bram_add_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  // Operand sum with the carry-out in the top bit.
  typedef logic [DEF_DATA_W:0] sum_t;

endpackage

// File: rtl/bram_add_pipe.sv
// Valid + address delay line matching the BRAM read latency.
module bram_add_pipe #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int unsigned AW_TOT = DEPTH * ADDR_W;

  logic [DEPTH-1:0]             vld;
  logic [DEPTH-1:0][ADDR_W-1:0] adr;
  logic [ADDR_W-1:0]            in_addr_g;

  // Idle slots carry a zero address so the write port reads 0 between writes.
  assign in_addr_g = in_valid ? in_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      adr <= '0;
    end else begin
      vld <= DEPTH'({vld, in_valid});
      adr <= AW_TOT'({adr, in_addr_g});
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_addr  = adr[DEPTH-1];

endmodule

// File: rtl/bram_add_seq.sv
// Sweeps an address range, adds bram1+bram2 words and writes the sums to bram3.
// Define BRAM_ADD_SATURATE_EN to saturate the written sum on carry-out instead of wrapping.
module bram_add_seq
  import bram_add_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              ena1,
  output logic [ADDR_W-1:0] addra1,
  input  logic [DATA_W-1:0] douta1,
  output logic              ena2,
  output logic [ADDR_W-1:0] addra2,
  input  logic [DATA_W-1:0] douta2,
  output logic              ena3,
  output logic              wea3,
  output logic [ADDR_W-1:0] addra3,
  output logic [DATA_W-1:0] dina3
);

  localparam int unsigned CNT_W = 2;

  seq_state_t        state, state_n;
  logic [ADDR_W-1:0] last_q, last_n;
  logic              rd_en_q, rd_en_n;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_n;
  logic [CNT_W-1:0]  drain_cnt, drain_cnt_n;
  logic              busy_n, done_n, ovf_n;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] wr_data;

  bram_add_pipe #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_en_q),
    .in_addr   (rd_addr_q),
    .out_valid (wr_valid),
    .out_addr  (wr_addr)
  );

  assign sum = {1'b0, douta1} + {1'b0, douta2};

`ifdef BRAM_ADD_SATURATE_EN
  assign wr_data = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
  assign wr_data = sum[DATA_W-1:0];
`endif

  // Next-state, read-issue and flag logic.
  always_comb begin
    state_n     = state;
    last_n      = last_q;
    rd_en_n     = 1'b0;
    rd_addr_n   = '0;
    drain_cnt_n = drain_cnt;
    ovf_n       = ovf;
    if (wr_valid && sum[DATA_W]) begin
      ovf_n = 1'b1;
    end
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = RUN;
          last_n    = last_addr;
          rd_en_n   = 1'b1;
          rd_addr_n = first_addr;
          ovf_n     = 1'b0;
        end
      end
      RUN: begin
        if (rd_addr_q == last_q) begin
          state_n     = DRAIN;
          drain_cnt_n = '0;
        end else begin
          rd_en_n   = 1'b1;
          rd_addr_n = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == CNT_W'(RD_LAT - 1)) begin
          state_n = DONE;
        end else begin
          drain_cnt_n = drain_cnt + CNT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN) || (state_n == DRAIN);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      last_q    <= last_n;
      rd_en_q   <= rd_en_n;
      rd_addr_q <= rd_addr_n;
      drain_cnt <= drain_cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      ovf       <= ovf_n;
    end
  end

  assign ena1   = rd_en_q;
  assign ena2   = rd_en_q;
  assign addra1 = rd_addr_q;
  assign addra2 = rd_addr_q;

  // Write port lines up with the read data emerging from the BRAMs.
  assign ena3   = wr_valid;
  assign wea3   = wr_valid;
  assign addra3 = wr_addr;
  assign dina3  = wr_valid ? wr_data : '0;

endmodule

// File: tb/tb_bram_add_seq.sv
// Scoreboard bench: two instances (read latency 1 and 2) driven by the same sweeps.
module tb_bram_add_seq;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NI = 2;
`ifdef BRAM_ADD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int     addr;
    int     data;
    bit     carry;
    longint cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [AW-1:0] first_addr, last_addr;

  logic [NI-1:0]         busy, done, ovf, ena1, ena2, ena3, wea3;
  logic [NI-1:0][AW-1:0] addra1, addra2, addra3;
  logic [NI-1:0][DW-1:0] douta1, douta2, dina3;
  logic [NI-1:0][DW-1:0] r1a, r1b, r2a, r2b;

  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem2 [256];

  longint cyc = 0;
  int total = 0;
  int bad = 0;

  int     sw_first [64];
  int     sw_last  [64];
  longint sw_t0    [64];
  int     sw_issued = 0;
  int     sw_seen = 0;

  exp_t          expq [NI][$];
  exp_t          e;
  bit [NI-1:0]   pending = '0;
  bit [NI-1:0]   ovf_m = '0;
  longint        done_at [NI];
  int            n_el [NI];
  int            busy_cnt [NI];
  int            idx, n, a, s, d;
  bit            c;
  longint        z;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bram_add_seq #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .RD_LAT (g + 1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .busy       (busy[g]),
      .done       (done[g]),
      .ovf        (ovf[g]),
      .ena1       (ena1[g]),
      .addra1     (addra1[g]),
      .douta1     (douta1[g]),
      .ena2       (ena2[g]),
      .addra2     (addra2[g]),
      .douta2     (douta2[g]),
      .ena3       (ena3[g]),
      .wea3       (wea3[g]),
      .addra3     (addra3[g]),
      .dina3      (dina3[g])
    );
    assign douta1[g] = (g == 0) ? r1a[g] : r1b[g];
    assign douta2[g] = (g == 0) ? r2a[g] : r2b[g];
  end

  // Read-only BRAM models: one registered stage, plus one more for latency 2.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (ena1[i]) r1a[i] <= mem1[addra1[i]];
      if (ena2[i]) r2a[i] <= mem2[addra2[i]];
    end
    r1b <= r1a;
    r2b <= r2a;
  end

  task automatic chk(input bit ok, input string name, input int g,
                     input longint act, input longint expv);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s lat=%0d cyc=%0d got=%0h want=%0h", name, g + 1, cyc, act, expv);
    end
  endtask

  // Monitor: builds expectations for each new sweep and checks every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        expq[i].delete();
        pending[i] = 1'b0;
        ovf_m[i] = 1'b0;
        z = longint'({busy[i], done[i], ovf[i], ena1[i], ena2[i], ena3[i], wea3[i],
                      addra1[i], addra2[i], addra3[i], dina3[i]});
        chk(z == 0, "reset_outputs_zero", i, z, 0);
      end
    end else begin
      if (sw_issued > sw_seen) begin
        idx = sw_seen;
        sw_seen++;
        n = ((sw_last[idx] - sw_first[idx]) & 255) + 1;
        for (int i = 0; i < NI; i++) begin
          expq[i].delete();
          for (int k = 0; k < n; k++) begin
            a = (sw_first[idx] + k) & 255;
            s = int'(mem1[a]) + int'(mem2[a]);
            c = (s > 65535);
            d = c ? (SAT ? 65535 : s - 65536) : s;
            expq[i].push_back('{a, d, c, sw_t0[idx] + 1 + k + (i + 1)});
          end
          done_at[i]  = sw_t0[idx] + n + (i + 1) + 1;
          n_el[i]     = n;
          busy_cnt[i] = 0;
          pending[i]  = 1'b1;
          ovf_m[i]    = 1'b0;
        end
      end
      for (int i = 0; i < NI; i++) begin
        chk(ovf[i] == ovf_m[i], "ovf", i, ovf[i], ovf_m[i]);
        if (busy[i]) busy_cnt[i]++;
        if (ena3[i]) begin
          if (expq[i].size() == 0) begin
            chk(1'b0, "unexpected_write", i, addra3[i], 0);
          end else begin
            e = expq[i].pop_front();
            chk(addra3[i] == AW'(e.addr), "write_addr", i, addra3[i], e.addr);
            chk(dina3[i] == DW'(e.data), "write_data", i, dina3[i], e.data);
            chk(cyc == e.cyc, "write_cycle", i, cyc, e.cyc);
            chk(wea3[i] == 1'b1, "write_we", i, wea3[i], 1);
            if (e.carry) ovf_m[i] = 1'b1;
          end
        end else begin
          z = longint'({wea3[i], addra3[i], dina3[i]});
          chk(z == 0, "idle_write_port", i, z, 0);
        end
        if (done[i]) begin
          if (!pending[i]) begin
            chk(1'b0, "unexpected_done", i, cyc, 0);
          end else begin
            chk(cyc == done_at[i], "done_cycle", i, cyc, done_at[i]);
            chk(busy[i] == 1'b0, "busy_at_done", i, busy[i], 0);
            chk(busy_cnt[i] == n_el[i] + i + 1, "busy_length", i, busy_cnt[i], n_el[i] + i + 1);
            chk(expq[i].size() == 0, "writes_missing", i, expq[i].size(), 0);
            pending[i] = 1'b0;
          end
        end else if (pending[i] && cyc > done_at[i] + 4) begin
          chk(1'b0, "done_timeout", i, cyc, done_at[i]);
          pending[i] = 1'b0;
        end
      end
    end
  end

  task automatic sweep(input int f, input int l);
    @(posedge clk);
    #1;
    start      = 1'b1;
    first_addr = AW'(f);
    last_addr  = AW'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    sw_first[sw_issued] = f;
    sw_last[sw_issued]  = l;
    sw_t0[sw_issued]    = cyc - 1;
    sw_issued++;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 2000 && pending != '0; w++) @(posedge clk);
    if (pending != '0) begin
      $display("FAIL wait_idle pending=%0b after 2000 cycles", pending);
      $fatal(1, "bench stalled");
    end
  endtask

  task automatic run(input int f, input int l);
    sweep(f, l);
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    first_addr = '0;
    last_addr = '0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = DW'(i);
      mem2[i] = 16'h0010;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run(0, 3);
    run(8'hFE, 8'h01);
    mem1[5] = 16'hFFFF;
    mem2[5] = 16'h0002;
    run(5, 5);
    repeat (6) @(posedge clk);
    run(4, 6);

    for (int i = 0; i < 256; i++) begin
      mem1[i] = DW'($urandom);
      mem2[i] = DW'($urandom);
    end
    for (int t = 0; t < 8; t++) begin
      a = int'($urandom_range(0, 255));
      run(a, (a + int'($urandom_range(0, 40))) & 255);
    end
    run(8'hFF, 8'hFF);
    run(8'hF0, 8'h0F);

    sweep(0, 255);
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1;
    first_addr = 8'h10;
    last_addr  = 8'h12;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    sweep(20, 29);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    run(30, 39);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
